// File: rtl/bf16_mul_pipe.sv
// Three-stage pipelined bfloat16 multiplier with valid/ready on both sides.
// Subnormals flush to zero, round-to-nearest-even; output format matches BF_adder.
module bf16_mul_pipe #(
    parameter int BIAS       = 127,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] p
);

    if (DATA_WIDTH != 16) begin : g_bad_width
        $error("bf16_mul_pipe: DATA_WIDTH must be 16");
    end

    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;

    // A stage may load when empty or when its current contents move on this cycle.
    assign load3    = !v3_q || out_ready;
    assign load2    = !v2_q || load3;
    assign load1    = !v1_q || load2;
    assign in_ready = load1;

    // ---------------- S1: operand register, classify ----------------
    logic [15:0] a1_q, b1_q;

    logic [7:0]        ea, eb;
    logic [6:0]        fa, fb;
    logic              za, zb, ia, ib, na, nb;
    logic              s1_sign, s1_nan, s1_inf, s1_zero;
    logic [15:0]       s1_prod;
    logic signed [9:0] s1_exp;

    always_comb begin
        ea      = a1_q[14:7];
        eb      = b1_q[14:7];
        fa      = a1_q[6:0];
        fb      = b1_q[6:0];
        za      = (ea == 8'h00);
        zb      = (eb == 8'h00);
        ia      = (ea == 8'hFF) && (fa == 7'h00);
        ib      = (eb == 8'hFF) && (fb == 7'h00);
        na      = (ea == 8'hFF) && (fa != 7'h00);
        nb      = (eb == 8'hFF) && (fb != 7'h00);
        s1_sign = a1_q[15] ^ b1_q[15];
        s1_nan  = na || nb || (ia && zb) || (za && ib);
        s1_inf  = ia || ib;
        s1_zero = za || zb;
        s1_prod = 16'({1'b1, fa}) * 16'({1'b1, fb});
        s1_exp  = signed'({2'b00, ea}) + signed'({2'b00, eb}) - signed'(10'(BIAS));
    end

    // ---------------- S2: significand product, exponent sum ----------------
    logic              s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
    logic [15:0]       m2_q;
    logic signed [9:0] e2_q;

    // ---------------- S3: normalize, round, pack ----------------
    logic [6:0]        frac_t;
    logic              guard, sticky, round_up;
    logic [7:0]        frac_r;
    logic signed [9:0] e_n, e_r;
    logic [15:0]       p_d, p_q;

    always_comb begin
        if (m2_q[15]) begin
            frac_t = m2_q[14:8];
            guard  = m2_q[7];
            sticky = |m2_q[6:0];
            e_n    = e2_q + 10'sd1;
        end else begin
            frac_t = m2_q[13:7];
            guard  = m2_q[6];
            sticky = |m2_q[5:0];
            e_n    = e2_q;
        end
        round_up = guard && (sticky || frac_t[0]);
        frac_r   = {1'b0, frac_t} + {7'h00, round_up};
        e_r      = frac_r[7] ? (e_n + 10'sd1) : e_n;

        if (s2_nan_q) begin
            p_d = 16'h7FC0;
        end else if (s2_inf_q) begin
            p_d = {s2_sign_q, 8'hFF, 7'h00};
        end else if (s2_zero_q) begin
            p_d = {s2_sign_q, 15'h0000};
        end else if (e_r >= 10'sd255) begin
            p_d = {s2_sign_q, 8'hFF, 7'h00};
        end else if (e_r <= 10'sd0) begin
            p_d = {s2_sign_q, 15'h0000};
        end else begin
            p_d = {s2_sign_q, e_r[7:0], frac_r[6:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            p_q  <= 16'h0000;
        end else begin
            if (load1) begin
                v1_q <= in_valid;
                a1_q <= a;
                b1_q <= b;
            end
            if (load2) begin
                v2_q      <= v1_q;
                s2_sign_q <= s1_sign;
                s2_nan_q  <= s1_nan;
                s2_inf_q  <= s1_inf;
                s2_zero_q <= s1_zero;
                m2_q      <= s1_prod;
                e2_q      <= s1_exp;
            end
            if (load3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    p_q <= p_d;
                end
            end
        end
    end

    assign out_valid = v3_q;
    assign p         = p_q;

endmodule
